mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one mem_control instance between the instruction-fetch port (f_*)
// and the load/store data port (d_*). Each granted access occupies the
// controller for two cycles: reads are issue + capture, writes are the
// controller's read-modify-write (enable pulse + held operands). Read data
// comes back on the owning port with a registered one-cycle valid pulse.
//
// Handshake: a requester raises *_req_i with its command fields and holds
// them unchanged until the cycle *_gnt_o is high; that cycle is the
// transfer. Grants are combinational from the requests and are only given
// in IDLE, at most one per cycle.
//
// Arbitration: data wins by default; once MAX_DATA_STREAK data grants have
// gone by while fetch was waiting, fetch is forced to win. Stores are only
// eligible when the controller reports mem_wr_ready_i, and a blocked store
// lets a waiting fetch through.
//
// Ports:
//   clk_i, rstn_i                    clock, async active-low reset
//   f_req_i, f_addr_i                fetch request (word read)
//   f_gnt_o, f_rvalid_o, f_rdata_o   fetch grant / read-data return
//   d_req_i, d_we_i, d_acc_i,
//   d_sext_i, d_addr_i, d_wdata_i    data request (load or store)
//   d_gnt_o, d_rvalid_o, d_rdata_o   data grant / load-data return
//   mem_r_en_o, mem_acc_r_o,
//   mem_addr_r_o, mem_sext_o         controller read port
//   mem_data_r_i                     controller read data (capture cycle)
//   mem_wr_en_o, mem_acc_w_o,
//   mem_addr_w_o, mem_data_w_o       controller write port
//   mem_wr_ready_i                   controller can accept a write
//   dbg_state_o                      FSM state (0 IDLE, 1 RD_CAPTURE, 2 WR_HOLD)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_acc_i,
    input  logic        d_sext_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,

    output logic        mem_r_en_o,
    output logic [1:0]  mem_acc_r_o,
    output logic [31:0] mem_addr_r_o,
    output logic        mem_sext_o,
    input  logic [31:0] mem_data_r_i,

    output logic        mem_wr_en_o,
    output logic [1:0]  mem_acc_w_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o,
    input  logic        mem_wr_ready_i,

    output logic [1:0]  dbg_state_o
);

    // Access-size encoding shared with mem_control.
    localparam logic [1:0] ACC_BYTE     = 2'b00;
    localparam logic [1:0] ACC_HALFWORD = 2'b01;
    localparam logic [1:0] ACC_WORD     = 2'b10;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_CAPTURE = 2'd1,
        WR_HOLD    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        run_q;
    logic [3:0]  streak_q, streak_d;

    // Latched copy of the granted access, replayed in the second cycle.
    logic        lat_is_f_q;
    logic        lat_we_q;
    logic [1:0]  lat_acc_q;
    logic        lat_sext_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;

    logic        f_rvalid_q, d_rvalid_q;
    logic [31:0] f_rdata_q, d_rdata_q;

    logic        d_eligible, fetch_forced;
    logic        grant_f, grant_d;
    logic        win_we, win_sext;
    logic [1:0]  win_acc;
    logic [31:0] win_addr, win_wdata;

    // ------------------------------------------------------------------
    // Winner selection. run_q keeps grants off until the first clock edge
    // after reset release, so every output is 0 while reset is asserted
    // without a combinational path from rstn_i.
    // ------------------------------------------------------------------
    always_comb begin
        d_eligible   = d_req_i & (~d_we_i | mem_wr_ready_i);
        fetch_forced = f_req_i & (streak_q == STREAK_MAX);
        grant_f      = 1'b0;
        grant_d      = 1'b0;
        if (run_q && (state_q == IDLE)) begin
            if (fetch_forced) begin
                grant_f = 1'b1;
            end else if (d_eligible) begin
                grant_d = 1'b1;
            end else if (f_req_i) begin
                grant_f = 1'b1;
            end
        end
    end

    // Fetch is always a plain word read.
    always_comb begin
        win_we    = grant_d & d_we_i;
        win_sext  = grant_d & d_sext_i;
        win_acc   = grant_d ? d_acc_i   : ACC_WORD;
        win_addr  = grant_d ? d_addr_i  : f_addr_i;
        win_wdata = grant_d ? d_wdata_i : 32'd0;
    end

    // ------------------------------------------------------------------
    // Next state and controller-port outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_r_en_o   = 1'b0;
        mem_acc_r_o  = ACC_BYTE;
        mem_addr_r_o = 32'd0;
        mem_sext_o   = 1'b0;
        mem_wr_en_o  = 1'b0;
        mem_acc_w_o  = ACC_BYTE;
        mem_addr_w_o = 32'd0;
        mem_data_w_o = 32'd0;
        case (state_q)
            IDLE: begin
                if (grant_f || grant_d) begin
                    if (win_we) begin
                        mem_wr_en_o  = 1'b1;
                        mem_acc_w_o  = win_acc;
                        mem_addr_w_o = win_addr;
                        mem_data_w_o = win_wdata;
                        state_d      = WR_HOLD;
                    end else begin
                        mem_r_en_o   = 1'b1;
                        mem_acc_r_o  = win_acc;
                        mem_addr_r_o = win_addr;
                        mem_sext_o   = win_sext;
                        state_d      = RD_CAPTURE;
                    end
                end
            end
            RD_CAPTURE: begin
                mem_r_en_o   = 1'b1;
                mem_acc_r_o  = lat_acc_q;
                mem_addr_r_o = lat_addr_q;
                mem_sext_o   = lat_sext_q;
                state_d      = IDLE;
            end
            WR_HOLD: begin
                // Enable already pulsed; operands stay put while the
                // controller finishes its read-modify-write.
                mem_acc_w_o  = lat_acc_q;
                mem_addr_w_o = lat_addr_q;
                mem_data_w_o = lat_wdata_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Streak counts data grants taken while fetch waits. Any fetch grant or
    // any cycle without a fetch request starts it over.
    always_comb begin
        streak_d = streak_q;
        if (!f_req_i || grant_f) begin
            streak_d = 4'd0;
        end else if (grant_d && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            streak_q    <= 4'd0;
            lat_is_f_q  <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_acc_q   <= ACC_BYTE;
            lat_sext_q  <= 1'b0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            f_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            streak_q <= streak_d;
            if (grant_f || grant_d) begin
                lat_is_f_q  <= grant_f;
                lat_we_q    <= win_we;
                lat_acc_q   <= win_acc;
                lat_sext_q  <= win_sext;
                lat_addr_q  <= win_addr;
                lat_wdata_q <= win_wdata;
            end
            f_rvalid_q <= (state_q == RD_CAPTURE) &  lat_is_f_q;
            d_rvalid_q <= (state_q == RD_CAPTURE) & ~lat_is_f_q;
            if (state_q == RD_CAPTURE) begin
                if (lat_is_f_q) begin
                    f_rdata_q <= mem_data_r_i;
                end else begin
                    d_rdata_q <= mem_data_r_i;
                end
            end
        end
    end

    assign f_gnt_o     = grant_f;
    assign d_gnt_o     = grant_d;
    assign f_rvalid_o  = f_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign f_rdata_o   = f_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign dbg_state_o = state_q;

    // lat_we_q only steers the state transition at grant time; it is kept
    // in the latch so the full access record is visible when debugging.
    logic unused_ok;
    assign unused_ok = lat_we_q ^ ACC_HALFWORD[0];

endmodule
